// File: rtl/spi_req_arbiter_pkg.sv
// Shared definitions for the SPI request arbiter: FSM encodings, limits, defaults.
package spi_req_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  localparam int NREQ_MAX      = 4;
  localparam int START_LEN_DEF = 10;
  localparam int TO_CYC_DEF    = 65535;
  localparam int DATA_W        = 32;
  localparam int DEPTH_W       = 16;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Signals between the arbiter and the shared SPI master.
// master: arbiter side (drives start/command); slave: SPI master side.
interface spi_req_arbiter_if;
  import spi_req_arbiter_pkg::*;

  logic               spi_start;
  logic               spi_dir;
  logic [DATA_W-1:0]  spi_data_tx;
  logic [DEPTH_W-1:0] spi_data_depth;
  logic               spi_ready;
  logic               spi_read_finish;
  logic [DATA_W-1:0]  spi_data_rx;

  modport master (
    output spi_start, spi_dir, spi_data_tx, spi_data_depth,
    input  spi_ready, spi_read_finish, spi_data_rx
  );

  modport slave (
    input  spi_start, spi_dir, spi_data_tx, spi_data_depth,
    output spi_ready, spi_read_finish, spi_data_rx
  );
endinterface

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin select: first active request at or after ptr, wrapping.
module spi_req_arbiter_rr_pick #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic [PW-1:0]   sel_idx,
  output logic            valid
);

  // Scan offsets from farthest to nearest so the nearest active request wins.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    valid   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[PW'((int'(ptr) + k) % NREQ)]) begin
        sel                                   = '0;
        sel[PW'((int'(ptr) + k) % NREQ)]      = 1'b1;
        sel_idx                               = PW'((int'(ptr) + k) % NREQ);
        valid                                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master between NREQ requesters with round-robin grant,
// start/ready sequencing, read-data return and a per-wait-state timeout.
module spi_req_arbiter
  import spi_req_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int START_LEN = START_LEN_DEF,
  parameter int TO_CYC    = TO_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_dir,
  input  logic [32*NREQ-1:0]   req_data_tx,
  input  logic [16*NREQ-1:0]   req_depth,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rsp_data,
  output logic                 rsp_timeout,
  output logic                 busy,
  spi_req_arbiter_if.master    spi
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t               state_reg, state_next;
  logic [15:0]          cnt_reg, cnt_next;
  logic [PW-1:0]        ptr_reg, ptr_next;
  logic [PW-1:0]        gnt_idx_reg, gnt_idx_next;
  logic [NREQ-1:0]      gnt_reg, gnt_next;
  logic [NREQ-1:0]      done_reg, done_next;
  logic [31:0]          rsp_data_reg, rsp_data_next;
  logic                 rsp_timeout_reg, rsp_timeout_next;
  logic                 start_reg, start_next;
  logic                 dir_reg, dir_next;
  logic [31:0]          tx_reg, tx_next;
  logic [15:0]          depth_reg, depth_next;
  logic                 seen_low_reg, seen_low_next;
  logic [31:0]          rx_reg, rx_next;

  logic [NREQ-1:0]      pick_sel;
  logic [PW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [31:0]          tx_arr [NREQ];
  logic [15:0]          depth_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign tx_arr[gi]    = req_data_tx[32*gi +: 32];
      assign depth_arr[gi] = req_depth[16*gi +: 16];
    end
  endgenerate

  spi_req_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req     (req),
    .ptr     (ptr_reg),
    .sel     (pick_sel),
    .sel_idx (pick_idx),
    .valid   (pick_valid)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg + 16'd1;
    ptr_next         = ptr_reg;
    gnt_idx_next     = gnt_idx_reg;
    gnt_next         = gnt_reg;
    done_next        = '0;
    rsp_data_next    = '0;
    rsp_timeout_next = 1'b0;
    start_next       = start_reg;
    dir_next         = dir_reg;
    tx_next          = tx_reg;
    depth_next       = depth_reg;
    seen_low_next    = seen_low_reg;
    rx_next          = rx_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        // A busy master (ready low) blocks granting entirely.
        if (pick_valid && spi.spi_ready) begin
          gnt_next      = pick_sel;
          gnt_idx_next  = pick_idx;
          dir_next      = req_dir[pick_idx];
          tx_next       = tx_arr[pick_idx];
          depth_next    = depth_arr[pick_idx];
          start_next    = 1'b1;
          seen_low_next = 1'b0;
          rx_next       = '0;
          state_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The master may accept while start is still high; remember that.
        if (!spi.spi_ready) seen_low_next = 1'b1;
        if (dir_reg && spi.spi_read_finish) rx_next = spi.spi_data_rx;
        if (cnt_reg == 16'(START_LEN - 1)) begin
          start_next = 1'b0;
          cnt_next   = '0;
          state_next = (seen_low_reg || !spi.spi_ready) ? ST_WAIT_DONE : ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!spi.spi_ready) begin
          cnt_next   = '0;
          state_next = ST_WAIT_DONE;
        end else if (cnt_reg == 16'(TO_CYC)) begin
          cnt_next         = '0;
          done_next        = gnt_reg;
          rsp_timeout_next = 1'b1;
          state_next       = ST_RESP;
        end
      end
      ST_WAIT_DONE: begin
        if (dir_reg && spi.spi_read_finish) rx_next = spi.spi_data_rx;
        if (spi.spi_ready) begin
          // read_finish coinciding with ready must still return the fresh word.
          cnt_next      = '0;
          done_next     = gnt_reg;
          rsp_data_next = !dir_reg ? 32'd0 :
                          (spi.spi_read_finish ? spi.spi_data_rx : rx_reg);
          state_next    = ST_RESP;
        end else if (cnt_reg == 16'(TO_CYC)) begin
          cnt_next         = '0;
          done_next        = gnt_reg;
          rsp_timeout_next = 1'b1;
          state_next       = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_next   = '0;
        gnt_next   = '0;
        ptr_next   = (gnt_idx_reg == PW'(NREQ - 1)) ? '0 : gnt_idx_reg + PW'(1);
        state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        gnt_next   = '0;
        start_next = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      ptr_reg         <= '0;
      gnt_idx_reg     <= '0;
      gnt_reg         <= '0;
      done_reg        <= '0;
      rsp_data_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
      start_reg       <= 1'b0;
      dir_reg         <= 1'b0;
      tx_reg          <= '0;
      depth_reg       <= '0;
      seen_low_reg    <= 1'b0;
      rx_reg          <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      ptr_reg         <= ptr_next;
      gnt_idx_reg     <= gnt_idx_next;
      gnt_reg         <= gnt_next;
      done_reg        <= done_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_timeout_reg <= rsp_timeout_next;
      start_reg       <= start_next;
      dir_reg         <= dir_next;
      tx_reg          <= tx_next;
      depth_reg       <= depth_next;
      seen_low_reg    <= seen_low_next;
      rx_reg          <= rx_next;
    end
  end

  assign gnt                = gnt_reg;
  assign done               = done_reg;
  assign rsp_data           = rsp_data_reg;
  assign rsp_timeout        = rsp_timeout_reg;
  assign busy               = (state_reg != ST_IDLE);
  assign spi.spi_start      = start_reg;
  assign spi.spi_dir        = dir_reg;
  assign spi.spi_data_tx    = tx_reg;
  assign spi.spi_data_depth = depth_reg;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a behavioural SPI master model.
module tb_spi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_dir = '0;
  logic [63:0] req_data_tx = '0;
  logic [31:0] req_depth = '0;
  logic [1:0]  gnt, done;
  logic [31:0] rsp_data;
  logic        rsp_timeout, busy;

  int vectors = 0;
  int miscompares = 0;

  spi_req_arbiter_if sif ();

  spi_req_arbiter #(.NREQ(2), .START_LEN(10), .TO_CYC(200)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_dir     (req_dir),
    .req_data_tx (req_data_tx),
    .req_depth   (req_depth),
    .gnt         (gnt),
    .done        (done),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .spi         (sif.master)
  );

  always #5 clk = ~clk;

  // SPI master model: ready low 3 cycles after start, 40-cycle transfer,
  // read_finish pulsed in the same cycle ready rises. Not reset by rst.
  logic        m_ready = 1'b1;
  logic        m_active = 1'b0;
  logic        m_dir = 1'b0;
  logic        m_finish = 1'b0;
  logic [31:0] m_rx = '0;
  int          m_cnt = 0;
  logic        m_stuck = 1'b0;
  logic        hold_low = 1'b0;
  logic [31:0] rx_value = '0;

  assign sif.spi_ready       = m_ready & ~hold_low;
  assign sif.spi_read_finish = m_finish;
  assign sif.spi_data_rx     = m_rx;

  always @(posedge clk) begin
    m_finish <= 1'b0;
    if (!m_active) begin
      if (sif.spi_start && !m_stuck) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
        m_dir    <= sif.spi_dir;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 2) m_ready <= 1'b0;
      if (m_cnt == 42) begin
        m_ready  <= 1'b1;
        m_active <= 1'b0;
        if (m_dir) begin
          m_finish <= 1'b1;
          m_rx     <= rx_value;
        end
      end
    end
  end

  // Monitors: width of the last spi_start pulse and any multi-bit grant.
  int   start_run = 0;
  int   last_start_len = 0;
  logic multi_gnt = 1'b0;
  always @(negedge clk) begin
    if (sif.spi_start) start_run++;
    else if (start_run != 0) begin
      last_start_len = start_run;
      start_run = 0;
    end
    if ($countones(gnt) > 1) multi_gnt = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step at least one cycle, then wait (bounded) for any done bit.
  task automatic wait_done(input int max_cyc, output int cyc, output logic [1:0] d);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == 2'b00 && cyc < max_cyc);
    d = done;
  endtask

  int         cyc;
  logic [1:0] d;
  logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_spi_start", sif.spi_start, 0);
    check("rst_spi_dir", sif.spi_dir, 0);
    check("rst_spi_data_tx", sif.spi_data_tx, 0);
    check("rst_spi_depth", sif.spi_data_depth, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single write from requester 0
    req_dir = 2'b00;
    req_data_tx[31:0] = 32'hAAAAAAAA;
    req_depth[15:0] = 16'd14;
    req = 2'b01;
    @(negedge clk);
    check("t1_gnt", gnt, 2'b01);
    check("t1_busy", busy, 1);
    check("t1_start", sif.spi_start, 1);
    check("t1_dir", sif.spi_dir, 0);
    check("t1_tx", sif.spi_data_tx, 32'hAAAAAAAA);
    check("t1_depth", sif.spi_data_depth, 16'd14);
    wait_done(200, cyc, d);
    check("t1_done", d, 2'b01);
    check("t1_rsp_data", rsp_data, 0);
    check("t1_rsp_timeout", rsp_timeout, 0);
    check("t1_start_len", last_start_len, 10);
    req = 2'b00;
    @(negedge clk);
    check("t1_done_pulse", done, 2'b00);
    @(negedge clk);
    check("t1_idle_gnt", gnt, 2'b00);
    check("t1_idle_busy", busy, 0);

    // 2: read from requester 1
    req_dir = 2'b10;
    req_data_tx[63:32] = 32'h12345678;
    req_depth[31:16] = 16'd24;
    rx_value = 32'h00AACC55;
    req = 2'b10;
    @(negedge clk);
    check("t2_gnt", gnt, 2'b10);
    check("t2_dir", sif.spi_dir, 1);
    check("t2_depth", sif.spi_data_depth, 16'd24);
    wait_done(200, cyc, d);
    check("t2_done", d, 2'b10);
    check("t2_rsp_data", rsp_data, 32'h00AACC55);
    check("t2_rsp_timeout", rsp_timeout, 0);
    req = 2'b00;
    repeat (2) @(negedge clk);

    // 3: both requests held continuously -> alternating grants
    req_dir = 2'b00;
    multi_gnt = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(200, cyc, d);
      check($sformatf("t3_order%0d", i), d, exp_order[i]);
    end
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("t3_onehot", multi_gnt, 0);

    // 4: master never accepts -> timeout
    m_stuck = 1'b1;
    req_dir = 2'b01;
    req = 2'b01;
    @(negedge clk);
    check("t4_gnt", gnt, 2'b01);
    wait_done(400, cyc, d);
    check("t4_done", d, 2'b01);
    check("t4_timeout", rsp_timeout, 1);
    check("t4_rsp_data", rsp_data, 0);
    check("t4_latency", cyc, 211);
    req = 2'b00;
    m_stuck = 1'b0;
    repeat (2) @(negedge clk);

    // 5: reset in WAIT_DONE, then a new request is served normally
    req_dir = 2'b01;
    rx_value = 32'hCAFEF00D;
    req = 2'b01;
    @(negedge clk);
    check("t5_gnt", gnt, 2'b01);
    repeat (25) @(negedge clk);
    check("t5_busy_mid", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_gnt", gnt, 2'b00);
    check("t5_rst_start", sif.spi_start, 0);
    check("t5_rst_busy", busy, 0);
    rst = 1'b0;
    wait_done(300, cyc, d);
    check("t5_done", d, 2'b01);
    check("t5_rsp_data", rsp_data, 32'hCAFEF00D);
    req = 2'b00;
    repeat (2) @(negedge clk);

    // 6: ready held low at idle blocks granting
    hold_low = 1'b1;
    req_dir = 2'b00;
    req_data_tx[31:0] = 32'h5A5A0F0F;
    req = 2'b01;
    repeat (20) @(negedge clk);
    check("t6_no_gnt", gnt, 2'b00);
    check("t6_no_busy", busy, 0);
    hold_low = 1'b0;
    @(negedge clk);
    check("t6_gnt", gnt, 2'b01);
    check("t6_tx", sif.spi_data_tx, 32'h5A5A0F0F);
    wait_done(200, cyc, d);
    check("t6_done", d, 2'b01);
    check("t6_rsp_data", rsp_data, 0);
    check("t6_start_len", last_start_len, 10);
    req = 2'b00;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
